fare_collector: RTL and testbench
=================================

// Module: fare_collector
// PURPOSE
//  Upstream stage of the ticket dispenser: accepts coin pulses, accumulates credit, and fires a one-cycle
//  ready pulse (tic_rdy, wired to the ticket stage's in_RDY9) once credit >= FARE.
//  Waits for the ticket stage's completion pulse (tic_done), then pays back change one unit per pulse.
// PARAMETERS
//  CW        8    credit/change counter width (bits)
//  FARE      9    ticket price in units; 1 <= FARE <= CREDIT_MAX
//  CREDIT_MAX 30  credit ceiling; coins that would exceed it are rejected; < 2**CW
//  D0..D3    1,2,5,10  unit value of coin_sel = 0..3
//  CHG_GAP   3    idle cycles between chg_pulse pulses (>= 1)
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    asynchronous, active-high reset
//  coin_valid  in   1    one-cycle strobe: a coin was inserted
//  coin_sel    in   2    denomination of the strobed coin
//  tic_done    in   1    one-cycle pulse from the ticket stage: ticket taken
//  cancel      in   1    refund request (present only with CANCEL_REFUND_EN)
//  tic_rdy     out  1    one-cycle pulse to the ticket stage: fare paid
//  coin_accept out  1    one-cycle pulse: strobed coin credited
//  coin_reject out  1    one-cycle pulse: strobed coin returned (busy or over CREDIT_MAX)
//  chg_pulse   out  1    one-cycle pulse per unit of change returned
//  credit      out  CW   current credit (registered)
//  busy        out  1    high in any state other than IDLE/COLLECT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, credit 0, chg count 0; takes effect immediately, mid-operation included.
//  Credit lost.
//  All outputs registered; accept/reject/tic_rdy appear 1 cycle after the causing edge.
//  FSM:
//   IDLE:    credit==0. coin_valid -> credit+=D[sel], accept, go to COLLECT.
//   COLLECT: coin_valid with credit+D <= CREDIT_MAX -> credit+=D, accept; else reject with credit unchanged.
//            When the post-update credit >= FARE, go to VEND on the same edge (coin on the paying cycle counts).
//   VEND:    tic_rdy=1 for exactly one cycle; chg count <= credit-FARE; go to WAIT_TIC.
//   WAIT_TIC: hold (credit stays displayed) until tic_done. tic_done -> credit <= 0;
//            go to CHANGE if chg count > 0, else IDLE.
//   CHANGE:  chg_pulse for 1 cycle, then CHG_GAP idle cycles; decrement per pulse. Return to IDLE after the last gap.
//  coin_valid in VEND/WAIT_TIC/CHANGE -> coin_reject pulse; credit untouched.
//  tic_done outside WAIT_TIC is ignored. tic_rdy is a pulse, never a level, so the ticket stage cannot re-trigger.
//  Credit arithmetic is unsigned CW-bit; the CREDIT_MAX check is done at CW+1 bits, so no wrap is possible.
//  Exactly-fare payment -> no CHANGE state; IDLE one cycle after tic_done.
// CONFIGURATION
//  CANCEL_REFUND_EN defined: cancel port exists.
//   In COLLECT, a cancel edge loads chg count <= credit and credit <= 0, then goes to CHANGE.
//   If cancel and coin_valid occur together: coin rejected, cancel wins.
//   cancel is ignored in all other states.
//  Not defined: no cancel port. Credit is only released by a vend.
// STRUCTURE
//  Shared package fare_pkg: state enum (IDLE, COLLECT, VEND, WAIT_TIC, CHANGE), coin_sel codes,
//  and the default denomination constants.
//  One sub-module, chg_pulser: loadable down-counter + gap timer that emits chg_pulse and a done flag.
//  The FSM and credit adder stay in fare_collector.
// TESTING
//  1 Coins 5,2,2 (sel 2,1,1) -> 3 accepts; tic_rdy pulse once, 1 cycle after 3rd accept edge;
//    credit=9; tic_done -> credit 0, no chg_pulse, IDLE.
//  2 Coins 10 -> tic_rdy; tic_done -> exactly 1 chg_pulse; then IDLE. Coins 10,5 with FARE=9 is
//    impossible (vend on 10), so use 5,5 -> chg 1.
//  3 Credit 8, coin 10 -> credit 18, tic_rdy, 9 chg_pulses spaced CHG_GAP+1=4 cycles; coin during
//    CHANGE -> coin_reject.
//  4 FARE=30 build: credit 25, coin 10 -> reject, credit stays 25; coin 5 -> accept, tic_rdy.
//  5 rst asserted mid-CHANGE (3 pulses left) -> outputs 0 asynchronously, no further chg_pulse, IDLE.
//  6 CANCEL_REFUND_EN: credit 7, cancel together with coin 2 -> reject, 7 chg_pulses, no tic_rdy;
//    without the macro, the port is absent and the build succeeds.

Source files
------------

// File: rtl/fare_pkg.sv
// Shared types and constants for the fare collector: FSM states, coin_sel codes
// and default coin denominations.
package fare_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_VEND,
      ST_WAIT_TIC,
      ST_CHANGE
   } state_t;

   localparam logic [1:0] SEL_D0 = 2'd0;
   localparam logic [1:0] SEL_D1 = 2'd1;
   localparam logic [1:0] SEL_D2 = 2'd2;
   localparam logic [1:0] SEL_D3 = 2'd3;

   localparam int DEF_D0 = 1;
   localparam int DEF_D1 = 2;
   localparam int DEF_D2 = 5;
   localparam int DEF_D3 = 10;

endpackage

// File: rtl/fare_collector_chg_pulser.sv
// Change pay-out timer: loadable unit down-counter plus gap down-counter that emits
// one chg_pulse per unit, followed by CHG_GAP idle cycles.
module chg_pulser #(
   parameter int CW      = 8,
   parameter int CHG_GAP = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          run,
   output logic          chg_pulse,
   output logic          cnt_zero,
   output logic          done
);

   localparam int GW = $clog2(CHG_GAP + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          pulse_q, pulse_d;

   // A pulse is only issued once the previous gap has fully expired.
   always_comb begin
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      pulse_d = 1'b0;
      if (load) begin
         cnt_d = load_val;
         gap_d = '0;
      end else if (run) begin
         if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
         end else if (cnt_q != '0) begin
            pulse_d = 1'b1;
            cnt_d   = cnt_q - 1'b1;
            gap_d   = GW'(CHG_GAP);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         gap_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         pulse_q <= pulse_d;
      end
   end

   assign chg_pulse = pulse_q;
   assign cnt_zero  = (cnt_q == '0);
   assign done      = run && (cnt_q == '0) && (gap_q == '0);

endmodule

// File: rtl/fare_collector.sv
// Coin credit accumulator and vend/change sequencer for the ticket dispenser.
// Optional CANCEL_REFUND_EN adds a cancel port that refunds credit while collecting.
//
// state       | meaning
// ST_IDLE     | no credit, waiting for first coin
// ST_COLLECT  | accumulating credit below FARE
// ST_VEND     | fare reached, issue tic_rdy and load change count
// ST_WAIT_TIC | waiting for the ticket stage's tic_done
// ST_CHANGE   | paying back change (or refund) via chg_pulser
module fare_collector
   import fare_pkg::*;
#(
   parameter int CW         = 8,
   parameter int FARE       = 9,
   parameter int CREDIT_MAX = 30,
   parameter int D0         = DEF_D0,
   parameter int D1         = DEF_D1,
   parameter int D2         = DEF_D2,
   parameter int D3         = DEF_D3,
   parameter int CHG_GAP    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          coin_valid,
   input  logic [1:0]    coin_sel,
   input  logic          tic_done,
`ifdef CANCEL_REFUND_EN
   input  logic          cancel,
`endif
   output logic          tic_rdy,
   output logic          coin_accept,
   output logic          coin_reject,
   output logic          chg_pulse,
   output logic [CW-1:0] credit,
   output logic          busy
);

   localparam logic [CW:0]   CMAX_W = (CW+1)'(CREDIT_MAX);
   localparam logic [CW-1:0] FARE_W = CW'(FARE);

   state_t        state_q, state_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          accept_q, accept_d;
   logic          reject_q, reject_d;
   logic          rdy_q, rdy_d;
   logic          busy_q, busy_d;
   logic [CW-1:0] coin_val;
   logic [CW:0]   sum;
   logic          ld;
   logic [CW-1:0] ld_val;
   logic          cnt_zero, chg_done;
   logic          cancel_in;

`ifdef CANCEL_REFUND_EN
   assign cancel_in = cancel;
`else
   assign cancel_in = 1'b0;
`endif

   always_comb begin
      case (coin_sel)
         SEL_D0:  coin_val = CW'(D0);
         SEL_D1:  coin_val = CW'(D1);
         SEL_D2:  coin_val = CW'(D2);
         default: coin_val = CW'(D3);
      endcase
   end

   // One extra bit so the ceiling compare cannot be fooled by a wrap.
   assign sum = {1'b0, credit_q} + {1'b0, coin_val};

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      accept_d = 1'b0;
      reject_d = 1'b0;
      rdy_d    = 1'b0;
      ld       = 1'b0;
      ld_val   = credit_q - FARE_W;
      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if ((state_q == ST_COLLECT) && cancel_in) begin
               reject_d = coin_valid;
               ld       = 1'b1;
               ld_val   = credit_q;
               credit_d = '0;
               state_d  = ST_CHANGE;
            end else if (coin_valid) begin
               if (sum <= CMAX_W) begin
                  credit_d = sum[CW-1:0];
                  accept_d = 1'b1;
                  state_d  = (sum >= {1'b0, FARE_W}) ? ST_VEND : ST_COLLECT;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         ST_VEND: begin
            rdy_d    = 1'b1;
            ld       = 1'b1;
            reject_d = coin_valid;
            state_d  = ST_WAIT_TIC;
         end
         ST_WAIT_TIC: begin
            reject_d = coin_valid;
            if (tic_done) begin
               credit_d = '0;
               state_d  = cnt_zero ? ST_IDLE : ST_CHANGE;
            end
         end
         ST_CHANGE: begin
            reject_d = coin_valid;
            if (chg_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = !(state_d inside {ST_IDLE, ST_COLLECT});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         credit_q <= '0;
         accept_q <= 1'b0;
         reject_q <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         accept_q <= accept_d;
         reject_q <= reject_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   chg_pulser #(
      .CW      (CW),
      .CHG_GAP (CHG_GAP)
   ) u_chg (
      .clk       (clk),
      .rst       (rst),
      .load      (ld),
      .load_val  (ld_val),
      .run       (state_q == ST_CHANGE),
      .chg_pulse (chg_pulse),
      .cnt_zero  (cnt_zero),
      .done      (chg_done)
   );

   assign tic_rdy     = rdy_q;
   assign coin_accept = accept_q;
   assign coin_reject = reject_q;
   assign credit      = credit_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_fare_collector.sv
// Bench for fare_collector: two instances (FARE 9 and FARE 30) share stimulus and
// are checked every cycle against a credit/schedule model, plus directed scenarios.
`timescale 1ns/1ps
module tb_fare_collector;

   localparam int CW   = 8;
   localparam int CMAX = 30;
   localparam int GAP  = 3;
`ifdef CANCEL_REFUND_EN
   localparam bit CANCEL_EN = 1'b1;
`else
   localparam bit CANCEL_EN = 1'b0;
`endif

   localparam int M_OPEN   = 0;
   localparam int M_VEND   = 1;
   localparam int M_WAIT   = 2;
   localparam int M_REFUND = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_sel = 2'd0;
   logic       tic_done = 1'b0;
   logic       cancel = 1'b0;

   logic [1:0]    acc, rej, rdy, pulse, busy;
   logic [CW-1:0] credit [2];

   int n_checks = 0;
   int n_err    = 0;

   // model state, index 0 = FARE 9, index 1 = FARE 30
   int m_mode [2];
   int m_credit [2];
   int m_owed [2];
   int m_start [2];
   bit m_acc [2], m_rej [2], m_rdy [2], m_pulse [2];
   int cyc = 0;

   always #5 clk = ~clk;

   fare_collector #(.CW(CW), .FARE(9), .CREDIT_MAX(CMAX), .D0(1), .D1(2), .D2(5), .D3(10),
                    .CHG_GAP(GAP)) dut9 (
      .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel), .tic_done(tic_done),
`ifdef CANCEL_REFUND_EN
      .cancel(cancel),
`endif
      .tic_rdy(rdy[0]), .coin_accept(acc[0]), .coin_reject(rej[0]), .chg_pulse(pulse[0]),
      .credit(credit[0]), .busy(busy[0]));

   fare_collector #(.CW(CW), .FARE(30), .CREDIT_MAX(CMAX), .D0(1), .D1(2), .D2(5), .D3(10),
                    .CHG_GAP(GAP)) dut30 (
      .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel), .tic_done(tic_done),
`ifdef CANCEL_REFUND_EN
      .cancel(cancel),
`endif
      .tic_rdy(rdy[1]), .coin_accept(acc[1]), .coin_reject(rej[1]), .chg_pulse(pulse[1]),
      .credit(credit[1]), .busy(busy[1]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0d want %0d", name, got, exp);
      end
   endtask

   function automatic int denom(input logic [1:0] s);
      case (s)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 5;
         default: return 10;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = M_OPEN; m_credit[i] = 0; m_owed[i] = 0; m_start[i] = 0;
         m_acc[i] = 0; m_rej[i] = 0; m_rdy[i] = 0; m_pulse[i] = 0;
      end
   endtask

   // Refund pulses land on edges start+1+(GAP+1)*k for k < owed; open again at k == owed.
   task automatic model_step();
      cyc++;
      for (int i = 0; i < 2; i++) begin
         int f, v, k;
         f = (i == 0) ? 9 : 30;
         m_acc[i] = 0; m_rej[i] = 0; m_rdy[i] = 0; m_pulse[i] = 0;
         case (m_mode[i])
            M_OPEN: begin
               if (CANCEL_EN && cancel && m_credit[i] > 0) begin
                  m_rej[i] = coin_valid;
                  m_owed[i] = m_credit[i];
                  m_credit[i] = 0;
                  m_mode[i] = M_REFUND;
                  m_start[i] = cyc;
               end else if (coin_valid) begin
                  v = denom(coin_sel);
                  if (m_credit[i] + v <= CMAX) begin
                     m_credit[i] += v;
                     m_acc[i] = 1;
                     if (m_credit[i] >= f) m_mode[i] = M_VEND;
                  end else begin
                     m_rej[i] = 1;
                  end
               end
            end
            M_VEND: begin
               m_rdy[i] = 1;
               m_rej[i] = coin_valid;
               m_owed[i] = m_credit[i] - f;
               m_mode[i] = M_WAIT;
            end
            M_WAIT: begin
               m_rej[i] = coin_valid;
               if (tic_done) begin
                  m_credit[i] = 0;
                  if (m_owed[i] > 0) begin
                     m_mode[i] = M_REFUND;
                     m_start[i] = cyc;
                  end else begin
                     m_mode[i] = M_OPEN;
                  end
               end
            end
            default: begin
               m_rej[i] = coin_valid;
               k = cyc - m_start[i] - 1;
               if ((k % (GAP + 1)) == 0 && (k / (GAP + 1)) < m_owed[i]) m_pulse[i] = 1;
               if (k == (GAP + 1) * m_owed[i]) m_mode[i] = M_OPEN;
            end
         endcase
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("cmp%0d_accept", i), 32'(acc[i]), 32'(m_acc[i]));
         check($sformatf("cmp%0d_reject", i), 32'(rej[i]), 32'(m_rej[i]));
         check($sformatf("cmp%0d_tic_rdy", i), 32'(rdy[i]), 32'(m_rdy[i]));
         check($sformatf("cmp%0d_chg_pulse", i), 32'(pulse[i]), 32'(m_pulse[i]));
         check($sformatf("cmp%0d_credit", i), 32'(credit[i]), 32'(m_credit[i]));
         check($sformatf("cmp%0d_busy", i), 32'(busy[i]), 32'(m_mode[i] != M_OPEN));
      end
   end

   // called at a falling edge; returns at the next falling edge with outputs of that cycle
   task automatic drive(input bit cv, input logic [1:0] sel, input bit td, input bit cn);
      coin_valid = cv; coin_sel = sel; tic_done = td; cancel = cn;
      @(negedge clk);
      coin_valid = 1'b0; tic_done = 1'b0; cancel = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int np, nr, first_p, second_p;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("reset_credit", 32'(credit[0]), 0);
      check("reset_busy", 32'(busy[0]), 0);

      // exact fare: 5,2,2
      drive(1, 2'd2, 0, 0);
      check("t1_acc1", 32'(acc[0]), 1);
      check("t1_credit1", 32'(credit[0]), 5);
      drive(1, 2'd1, 0, 0);
      drive(1, 2'd1, 0, 0);
      check("t1_credit", 32'(credit[0]), 9);
      check("t1_model_credit", 32'(m_credit[0]), 9);
      check("t1_rdy_early", 32'(rdy[0]), 0);
      drive(0, 2'd0, 0, 0);
      check("t1_rdy", 32'(rdy[0]), 1);
      check("t1_busy", 32'(busy[0]), 1);
      drive(0, 2'd0, 0, 0);
      check("t1_rdy_pulse", 32'(rdy[0]), 0);
      drive(0, 2'd0, 1, 0);
      check("t1_credit_clr", 32'(credit[0]), 0);
      check("t1_idle", 32'(busy[0]), 0);
      np = 0;
      for (int c = 0; c < 8; c++) begin
         drive(0, 2'd0, 0, 0);
         if (pulse[0]) np++;
      end
      check("t1_no_change", np, 0);

      // 5,5 -> one unit of change
      do_reset();
      drive(1, 2'd2, 0, 0);
      drive(1, 2'd2, 0, 0);
      check("t2_credit", 32'(credit[0]), 10);
      drive(0, 2'd0, 0, 0);
      check("t2_rdy", 32'(rdy[0]), 1);
      drive(0, 2'd0, 1, 0);
      np = 0;
      for (int c = 0; c < 10; c++) begin
         drive(0, 2'd0, 0, 0);
         if (pulse[0]) np++;
      end
      check("t2_pulses", np, 1);
      check("t2_idle", 32'(busy[0]), 0);

      // credit 8 + coin 10 -> 9 change pulses, coin rejected during change
      do_reset();
      drive(1, 2'd2, 0, 0);
      drive(1, 2'd1, 0, 0);
      drive(1, 2'd0, 0, 0);
      drive(1, 2'd3, 0, 0);
      check("t3_credit", 32'(credit[0]), 18);
      drive(0, 2'd0, 0, 0);
      check("t3_rdy", 32'(rdy[0]), 1);
      drive(0, 2'd0, 1, 0);
      np = 0; first_p = -1; second_p = -1;
      for (int c = 0; c < 40; c++) begin
         drive(c == 5, 2'd3, 0, 0);
         if (c == 5) begin
            check("t3_reject", 32'(rej[0]), 1);
            check("t3_credit_hold", 32'(credit[0]), 0);
         end
         if (pulse[0]) begin
            np++;
            if (first_p < 0) first_p = c;
            else if (second_p < 0) second_p = c;
         end
      end
      check("t3_pulses", np, 9);
      check("t3_spacing", second_p - first_p, 4);
      check("t3_idle", 32'(busy[0]), 0);

      // FARE 30 instance: ceiling reject then exact vend
      do_reset();
      drive(1, 2'd3, 0, 0);
      drive(1, 2'd3, 0, 0);
      drive(1, 2'd2, 0, 0);
      check("t4_credit25", 32'(credit[1]), 25);
      drive(1, 2'd3, 0, 0);
      check("t4_reject", 32'(rej[1]), 1);
      check("t4_credit_kept", 32'(credit[1]), 25);
      drive(1, 2'd2, 0, 0);
      check("t4_accept", 32'(acc[1]), 1);
      check("t4_credit30", 32'(credit[1]), 30);
      drive(0, 2'd0, 0, 0);
      check("t4_rdy", 32'(rdy[1]), 1);

      // reset during change with 3 pulses still owed
      do_reset();
      drive(1, 2'd2, 0, 0);
      drive(1, 2'd1, 0, 0);
      drive(1, 2'd0, 0, 0);
      drive(1, 2'd3, 0, 0);
      drive(0, 2'd0, 0, 0);
      drive(0, 2'd0, 1, 0);
      np = 0;
      for (int c = 0; c < 40 && np < 6; c++) begin
         drive(0, 2'd0, 0, 0);
         if (pulse[0]) np++;
      end
      check("t5_reached6", np, 6);
      #2 rst = 1'b1;
      #1;
      check("t5_async_pulse", 32'(pulse[0]), 0);
      check("t5_async_busy", 32'(busy[0]), 0);
      check("t5_async_credit", 32'(credit[0]), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      np = 0;
      for (int c = 0; c < 16; c++) begin
         drive(0, 2'd0, 0, 0);
         if (pulse[0]) np++;
      end
      check("t5_no_more", np, 0);
      check("t5_idle", 32'(busy[0]), 0);

`ifdef CANCEL_REFUND_EN
      // cancel with simultaneous coin: coin rejected, full refund
      do_reset();
      drive(1, 2'd2, 0, 0);
      drive(1, 2'd1, 0, 0);
      check("t6_credit7", 32'(credit[0]), 7);
      drive(1, 2'd1, 0, 1);
      check("t6_reject", 32'(rej[0]), 1);
      check("t6_credit0", 32'(credit[0]), 0);
      np = 0; nr = 0;
      for (int c = 0; c < 35; c++) begin
         drive(0, 2'd0, 0, 0);
         if (pulse[0]) np++;
         if (rdy[0]) nr++;
      end
      check("t6_pulses", np, 7);
      check("t6_no_rdy", nr, 0);
`endif

      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         drive($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
